// File: rtl/apb4_cfg_regbank.sv
// APB4 slave holding NUM_REGS masked RW config registers plus one W1C status
// register with a level interrupt. Access phase can be stretched by WAIT_STATES.
module apb4_cfg_regbank #(
    parameter int                     NUM_REGS    = 4,
    parameter int                     WAIT_STATES = 0,
    parameter logic [NUM_REGS*32-1:0] RESET_VALS  = '0,
    parameter logic [NUM_REGS*32-1:0] WR_MASK     = '1,
    parameter int                     STATUS_W    = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     psel,
    input  logic                     penable,
    input  logic                     pwrite,
    input  logic [7:0]               paddr,
    input  logic [31:0]              pwdata,
    input  logic [3:0]               pstrb,
    output logic                     pready,
    output logic [31:0]              prdata,
    output logic                     pslverr,
    input  logic [STATUS_W-1:0]      hw_set,
    output logic [NUM_REGS*32-1:0]   cfg,
    output logic [NUM_REGS-1:0]      cfg_wr_pulse,
    output logic [STATUS_W-1:0]      status,
    output logic                     irq
);

    localparam logic [5:0] STATUS_IDX = 6'(NUM_REGS);
    localparam logic [2:0] WAIT_INIT  = 3'(WAIT_STATES);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_e;

    state_e                 state_q, state_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [NUM_REGS*32-1:0] cfg_q, cfg_d;
    logic [NUM_REGS-1:0]    pulse_q, pulse_d;
    logic [STATUS_W-1:0]    status_q, status_d;
    logic [STATUS_W-1:0]    status_clr;
    logic                   irq_q;

    logic [5:0]  idx;
    logic        addr_err;
    logic [31:0] strb_mask;
    logic        xfer_done;
    logic        commit_wr;

    assign idx       = paddr[7:2];
    assign addr_err  = (paddr[1:0] != 2'b00) || (idx > STATUS_IDX);
    assign strb_mask = {{8{pstrb[3]}}, {8{pstrb[2]}}, {8{pstrb[1]}}, {8{pstrb[0]}}};
    assign xfer_done = (state_q == S_WAIT) && psel && penable && (cnt_q == 3'd0);
    assign commit_wr = xfer_done && pwrite && !addr_err;

    // NOTE: every variable driven in always_comb gets a default first; a path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (psel && !penable) begin
                    state_d = S_WAIT;
                    cnt_d   = WAIT_INIT;
                end
            end
            S_WAIT: begin
                // Master abandoning the transfer mid-wait: drop it without commit.
                if (!psel) begin
                    state_d = S_IDLE;
                end else if (penable) begin
                    if (cnt_q == 3'd0) state_d = S_IDLE;
                    else               cnt_d   = cnt_q - 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cfg_d      = cfg_q;
        pulse_d    = '0;
        status_clr = '0;
        if (commit_wr) begin
            if (idx == STATUS_IDX) begin
                status_clr = pwdata[STATUS_W-1:0] & strb_mask[STATUS_W-1:0];
            end else begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (idx == 6'(i)) begin
                        cfg_d[32*i +: 32] =
                            (cfg_q[32*i +: 32] & ~(strb_mask & WR_MASK[32*i +: 32])) |
                            (pwdata            &  (strb_mask & WR_MASK[32*i +: 32]));
                        pulse_d[i] = 1'b1;
                    end
                end
            end
        end
        // hw_set is OR-ed in last so a simultaneous set wins over a clear.
        status_d = (status_q & ~status_clr) | hw_set;
    end

    always_comb begin
        prdata = '0;
        if (xfer_done && !pwrite && !addr_err) begin
            if (idx == STATUS_IDX) begin
                prdata[STATUS_W-1:0] = status_q;
            end else begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (idx == 6'(i)) prdata = cfg_q[32*i +: 32];
                end
            end
        end
    end

    assign pready  = xfer_done;
    assign pslverr = xfer_done && addr_err;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            cfg_q    <= RESET_VALS;
            pulse_q  <= '0;
            status_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cfg_q    <= cfg_d;
            pulse_q  <= pulse_d;
            status_q <= status_d;
            irq_q    <= |status_d;
        end
    end

    assign cfg          = cfg_q;
    assign cfg_wr_pulse = pulse_q;
    assign status       = status_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_apb4_cfg_regbank.sv
// Bench for apb4_cfg_regbank: two instances (0 and 3 wait states) share the APB
// bus except psel; results are compared against an array-based register model.
module tb_apb4_cfg_regbank;

    localparam int N = 4;
    localparam logic [127:0] RV_A = {32'hCAFEF00D, 32'h12345678, 32'h00000000, 32'h00000000};
    localparam logic [127:0] WM_A = {32'hFFFFFFFF, 32'hFF00FF00, 32'hFFFFFFFF, 32'h00000007};
    localparam logic [127:0] RV_B = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00C0FFEE};
    localparam logic [127:0] WM_B = {128{1'b1}};

    logic         clk;
    logic         rstn;
    logic         psel [2];
    logic         penable;
    logic         pwrite;
    logic [7:0]   paddr;
    logic [31:0]  pwdata;
    logic [3:0]   pstrb;
    logic         pready [2];
    logic [31:0]  prdata [2];
    logic         pslverr [2];
    logic [7:0]   hw_set [2];
    logic [127:0] cfg [2];
    logic [3:0]   cfg_wr_pulse [2];
    logic [7:0]   status [2];
    logic         irq [2];

    apb4_cfg_regbank #(
        .NUM_REGS(N), .WAIT_STATES(0), .RESET_VALS(RV_A), .WR_MASK(WM_A), .STATUS_W(8)
    ) dut_a (
        .clk(clk), .rstn(rstn), .psel(psel[0]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pready(pready[0]),
        .prdata(prdata[0]), .pslverr(pslverr[0]), .hw_set(hw_set[0]), .cfg(cfg[0]),
        .cfg_wr_pulse(cfg_wr_pulse[0]), .status(status[0]), .irq(irq[0])
    );

    apb4_cfg_regbank #(
        .NUM_REGS(N), .WAIT_STATES(3), .RESET_VALS(RV_B), .WR_MASK(WM_B), .STATUS_W(8)
    ) dut_b (
        .clk(clk), .rstn(rstn), .psel(psel[1]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pready(pready[1]),
        .prdata(prdata[1]), .pslverr(pslverr[1]), .hw_set(hw_set[1]), .cfg(cfg[1]),
        .cfg_wr_pulse(cfg_wr_pulse[1]), .status(status[1]), .irq(irq[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    logic [31:0] m_cfg [2][N];
    logic [7:0]  m_stat [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rv(input int d, input int i);
        return (d == 0) ? RV_A[32*i +: 32] : RV_B[32*i +: 32];
    endfunction

    function automatic logic [31:0] wm(input int d, input int i);
        return (d == 0) ? WM_A[32*i +: 32] : WM_B[32*i +: 32];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < N; i++) m_cfg[d][i] = rv(d, i);
            m_stat[d] = '0;
        end
    endtask

    // Reference behaviour of one completed transfer, including hw_set present
    // in its commit cycle.
    task automatic model_xfer(input int d, input bit wr, input logic [7:0] addr,
                              input logic [31:0] data, input logic [3:0] strb,
                              input logic [7:0] hw, output logic exp_err,
                              output logic [31:0] exp_rd, output logic [3:0] exp_pls);
        int          idx;
        logic [31:0] bm;
        logic [31:0] m;
        logic [7:0]  clr;
        idx     = int'(addr[7:2]);
        exp_err = (addr[1:0] != 2'b00) || (idx > N);
        exp_rd  = '0;
        exp_pls = '0;
        clr     = '0;
        for (int b = 0; b < 4; b++) bm[8*b +: 8] = strb[b] ? 8'hFF : 8'h00;
        if (!exp_err) begin
            if (!wr) begin
                exp_rd = (idx == N) ? {24'h0, m_stat[d]} : m_cfg[d][idx];
            end else if (idx == N) begin
                clr = data[7:0] & bm[7:0];
            end else begin
                m = bm & wm(d, idx);
                m_cfg[d][idx] = (m_cfg[d][idx] & ~m) | (data & m);
                exp_pls = 4'(1 << idx);
            end
        end
        m_stat[d] = (m_stat[d] & ~clr) | hw;
    endtask

    task automatic apb(input int d, input bit wr, input logic [7:0] addr,
                       input logic [31:0] data, input logic [3:0] strb, input logic [7:0] hw,
                       output logic [31:0] rd, output logic err, output int waits,
                       output logic [3:0] pls);
        @(negedge clk);
        psel[d] = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        pstrb   = strb;
        @(negedge clk);
        penable = 1'b1;
        waits   = 0;
        #1;
        while (!pready[d] && waits < 20) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (!pready[d]) check("pready_timeout", 32'(pready[d]), 32'd1);
        rd        = prdata[d];
        err       = pslverr[d];
        hw_set[d] = hw;
        @(negedge clk);
        psel[d]   = 1'b0;
        penable   = 1'b0;
        hw_set[d] = '0;
        pls       = cfg_wr_pulse[d];
    endtask

    task automatic do_xfer(input int d, input bit wr, input logic [7:0] addr,
                           input logic [31:0] data, input logic [3:0] strb,
                           input logic [7:0] hw, input string tag);
        logic [31:0] rd, e_rd;
        logic        err, e_err;
        logic [3:0]  pls, e_pls;
        int          waits;
        model_xfer(d, wr, addr, data, strb, hw, e_err, e_rd, e_pls);
        apb(d, wr, addr, data, strb, hw, rd, err, waits, pls);
        check({tag, "_pslverr"}, 32'(err), 32'(e_err));
        check({tag, "_prdata"}, rd, e_rd);
        check({tag, "_waits"}, 32'(waits), (d == 0) ? 32'd0 : 32'd3);
        check({tag, "_pulse"}, 32'(pls), 32'(e_pls));
    endtask

    task automatic check_state(input string tag);
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < N; i++)
                check($sformatf("%s_cfg%0d_%0d", tag, d, i), cfg[d][32*i +: 32], m_cfg[d][i]);
            check($sformatf("%s_status%0d", tag, d), 32'(status[d]), 32'(m_stat[d]));
            check($sformatf("%s_irq%0d", tag, d), 32'(irq[d]), 32'(|m_stat[d]));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn      = 1'b0;
        psel[0]   = 1'b1;
        psel[1]   = 1'b1;
        penable   = 1'b1;
        pwrite    = 1'b0;
        paddr     = 8'h00;
        pwdata    = '0;
        pstrb     = '0;
        hw_set[0] = '0;
        hw_set[1] = '0;
        model_reset();

        // Bus driven active while in reset: outputs must stay quiet.
        repeat (3) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_pready%0d", d), 32'(pready[d]), 32'd0);
            check($sformatf("rst_prdata%0d", d), prdata[d], 32'd0);
            check($sformatf("rst_pslverr%0d", d), 32'(pslverr[d]), 32'd0);
            check($sformatf("rst_pulse%0d", d), 32'(cfg_wr_pulse[d]), 32'd0);
        end
        check_state("rst");
        @(negedge clk);
        psel[0] = 1'b0;
        psel[1] = 1'b0;
        penable = 1'b0;
        rstn    = 1'b1;

        for (int i = 0; i <= N; i++)
            do_xfer(0, 1'b0, 8'(i * 4), 32'h0, 4'h0, 8'h00, $sformatf("rd_reset%0d", i));

        do_xfer(0, 1'b1, 8'h04, 32'hA5A5A5A5, 4'b0101, 8'h00, "wr_reg1");
        @(negedge clk);
        check("wr_reg1_pulse_off", 32'(cfg_wr_pulse[0]), 32'd0);
        check("wr_reg1_cfg", cfg[0][63:32], 32'h00A500A5);
        do_xfer(0, 1'b0, 8'h04, 32'h0, 4'h0, 8'h00, "rd_reg1");

        do_xfer(0, 1'b1, 8'h00, 32'hFFFFFFFF, 4'hF, 8'h00, "wr_mask0");
        check("wr_mask0_cfg", cfg[0][31:0], 32'h00000007);
        do_xfer(0, 1'b0, 8'h00, 32'h0, 4'h0, 8'h00, "rd_mask0");
        do_xfer(0, 1'b1, 8'h08, 32'hFFFFFFFF, 4'hF, 8'h00, "wr_mask2");
        do_xfer(0, 1'b0, 8'h08, 32'h0, 4'h0, 8'h00, "rd_mask2");

        do_xfer(1, 1'b0, 8'h00, 32'h0, 4'h0, 8'h00, "rd_ws3");
        do_xfer(1, 1'b1, 8'h08, 32'hFFFFFFFF, 4'h0, 8'h00, "wr_nostrb");

        // Master drops psel after two wait cycles: nothing may commit.
        @(negedge clk);
        psel[1] = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 8'h00;
        pwdata  = 32'hFFFFFFFF;
        pstrb   = 4'hF;
        @(negedge clk);
        penable = 1'b1;
        #1;
        check("abort_wait1", 32'(pready[1]), 32'd0);
        @(negedge clk);
        #1;
        check("abort_wait2", 32'(pready[1]), 32'd0);
        @(negedge clk);
        psel[1] = 1'b0;
        penable = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("abort_pulse", 32'(cfg_wr_pulse[1]), 32'd0);
        end
        check_state("abort");
        do_xfer(1, 1'b0, 8'h00, 32'h0, 4'h0, 8'h00, "rd_after_abort");

        // Status: hardware set, simultaneous set/clear, then plain clear.
        @(negedge clk);
        hw_set[0] = 8'h01;
        @(negedge clk);
        hw_set[0] = 8'h00;
        m_stat[0] = m_stat[0] | 8'h01;
        #1;
        check("hwset_status", 32'(status[0]), 32'h01);
        check("hwset_irq", 32'(irq[0]), 32'd1);
        do_xfer(0, 1'b1, 8'h10, 32'h00000001, 4'hF, 8'h01, "w1c_with_set");
        check("w1c_with_set_status", 32'(status[0]), 32'h01);
        do_xfer(0, 1'b1, 8'h10, 32'h00000001, 4'hF, 8'h00, "w1c_alone");
        check("w1c_alone_status", 32'(status[0]), 32'h00);
        check("w1c_alone_irq", 32'(irq[0]), 32'd0);
        do_xfer(1, 1'b1, 8'h10, 32'h0, 4'h0, 8'h80, "hw_in_commit");
        do_xfer(1, 1'b0, 8'h10, 32'h0, 4'h0, 8'h00, "rd_status80");
        do_xfer(1, 1'b1, 8'h10, 32'h000000FF, 4'hE, 8'h00, "w1c_wrong_byte");
        do_xfer(1, 1'b1, 8'h10, 32'h00000080, 4'h1, 8'h00, "w1c_bit7");
        check_state("status");

        // Error responses leave everything untouched.
        do_xfer(0, 1'b1, 8'(N * 4 + 4), 32'hFFFFFFFF, 4'hF, 8'h00, "err_wr_hi");
        do_xfer(0, 1'b0, 8'(N * 4 + 4), 32'h0, 4'h0, 8'h00, "err_rd_hi");
        do_xfer(0, 1'b1, 8'h02, 32'hFFFFFFFF, 4'hF, 8'h00, "err_wr_mis");
        do_xfer(1, 1'b0, 8'h02, 32'h0, 4'h0, 8'h00, "err_rd_mis");
        check_state("err");

        for (int t = 0; t < 60; t++) begin
            int         d;
            int         idx;
            logic [1:0] mis;
            logic [7:0] hw;
            d   = int'($urandom_range(0, 1));
            idx = int'($urandom_range(0, 6));
            mis = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            hw  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            do_xfer(d, 1'($urandom), 8'(idx * 4) | 8'(mis), $urandom, 4'($urandom), hw,
                    $sformatf("rand%0d", t));
        end
        check_state("rand");

        // Reset asserted in the middle of a waited transfer.
        @(negedge clk);
        psel[1] = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 8'h08;
        pwdata  = 32'h5A5A5A5A;
        pstrb   = 4'hF;
        @(negedge clk);
        penable = 1'b1;
        #2;
        rstn = 1'b0;
        #1;
        check("midrst_pready", 32'(pready[1]), 32'd0);
        check("midrst_prdata", prdata[1], 32'd0);
        check("midrst_pslverr", 32'(pslverr[1]), 32'd0);
        model_reset();
        check_state("midrst");
        @(negedge clk);
        psel[1] = 1'b0;
        penable = 1'b0;
        rstn    = 1'b1;
        do_xfer(1, 1'b0, 8'h08, 32'h0, 4'h0, 8'h00, "rd_after_rst_b");
        do_xfer(0, 1'b0, 8'h0C, 32'h0, 4'h0, 8'h00, "rd_after_rst_a");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/apb4_cfg_regbank.md
Name: apb4_cfg_regbank

Overview:
Parametrised APB4-slave bank of configuration registers. It is the next generation of the single hard-wired config register.
- NUM_REGS read/write config registers, with per-bit write masks and per-register reset values.
- APB4 byte strobes, programmable wait states and error response.
- One W1C status register set by hardware, driving a level interrupt.
- Sits behind the AXI4-Lite-to-APB4 bridge; feeds master/peripheral control fields.

Parameters:
NUM_REGS, 4, number of RW config registers (1..16)
WAIT_STATES, 0, extra access-phase cycles before pready (0..7)
RESET_VALS, all-zero, NUM_REGS*32-bit flat vector; reg i reset value = bits [32*i+31:32*i]
WR_MASK, all-ones, NUM_REGS*32-bit flat vector; 1 = bit writable by software
STATUS_W, 8, width of status register (1..32)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
psel  in  1  APB select
penable  in  1  APB enable
pwrite  in  1  1 = write
paddr  in  8  byte address
pwdata  in  32  write data
pstrb  in  4  byte write strobes
pready  out  1  transfer complete
prdata  out  32  read data
pslverr  out  1  error response
hw_set  in  STATUS_W  per-bit status set pulses
cfg  out  NUM_REGS*32  config register contents, flat
cfg_wr_pulse  out  NUM_REGS  one-cycle pulse after a committed write to reg i
status  out  STATUS_W  status register
irq  out  1  interrupt level

Behaviour:
Reset:
- Asynchronous on rstn low: cfg = RESET_VALS; status = 0; cfg_wr_pulse = 0; irq = 0; wait counter = 0; FSM = IDLE.
- pready, prdata and pslverr read 0 while in reset.

Address map:
- reg index = paddr[7:2].
- Index 0..NUM_REGS-1: config registers.
- Index NUM_REGS: status register.
- Other indices, or paddr[1:0] != 0: error.

FSM:
- IDLE: psel=1 and penable=0 (setup) -> WAIT, load counter with WAIT_STATES.
- WAIT: counter decrements each cycle while psel&penable. pready=1 when counter==0; commit in that cycle; -> IDLE.
- WAIT_STATES=0: pready=1 in the first access cycle (2-cycle transfer).
- psel dropping in WAIT (protocol violation): -> IDLE, no commit.

Outputs and commit rules:
- pready is combinational from FSM/counter and is 0 outside the access phase.
- prdata is valid only when psel&penable&pready&!pwrite; 0 otherwise. Status reads zero-extended.
- pslverr is asserted only together with pready, for error addresses. On error: no state change, prdata=0.
- Config write: new bit = (pstrb[byte] & WR_MASK bit) ? pwdata bit : old bit. Non-writable bits keep their reset value. pstrb=0 commits nothing but still pulses.
- cfg_wr_pulse[i] is registered, high the cycle after a commit to reg i, for exactly 1 cycle.
- Status write: W1C; clear bits where pwdata=1 and the byte strobe is set.
- hw_set has priority: a bit set and cleared in the same cycle ends up 1.
- status updates every cycle: status <= (status & ~clr) | hw_set.
- irq is registered: irq <= |next_status, so irq follows status by 0 cycles as seen at the flop output.
- Reads have no side effects.
- Reset mid-transfer aborts the transfer; registers return to reset values.

Test Plan:
- Reset then read every index, WAIT_STATES=0 -> prdata = RESET_VALS per reg, status read 0, pready 1 cycle after setup, pslverr=0.
- Write 0xA5A5A5A5 with pstrb=4'b0101 to reg 1 (old 0x00000000, WR_MASK all ones) -> reg1=0x00A500A5; cfg_wr_pulse[1] high exactly 1 cycle after commit; other pulses 0.
- WR_MASK reg0=0x00000007, write 0xFFFFFFFF -> readback 0x00000007; upper bits hold reset value.
- WAIT_STATES=3: a read -> pready low for 3 access cycles, high on 4th; data correct; psel drop at wait 2 -> no commit, FSM IDLE.
- hw_set=0x01 pulse -> status=0x01, irq=1. Write 0x01 to status together with hw_set=0x01 -> status stays 0x01. Write 0x01 alone -> status 0, irq 0.
- Access paddr=NUM_REGS*4+4 and paddr=0x02 -> pslverr=1 with pready, prdata=0, no register or status change, no pulse.
